// File: rtl/lif_mon_pkg.sv
// Shared widths, the "no ISI" marker and the window summary record for the LIF spike monitor.
// Constants only: no latency and no flow control.
package lif_mon_pkg;

    localparam int DEF_U_W   = 3;
    localparam int DEF_WIN_W = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_ISI_W = 8;

    localparam logic [DEF_ISI_W-1:0] ISI_NONE = '1;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] count;
        logic [DEF_U_W-1:0]   u_max;
        logic [DEF_ISI_W-1:0] isi_min;
    } summary_t;

endpackage

// File: rtl/lif_spike_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Latency: q updates on the edge after clr/inc. No backpressure; at_max freezes the count.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         at_max
);

    logic [W-1:0] r_q;

    assign q      = r_q;
    assign at_max = &r_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_q <= '0;
        end else if (inc && !at_max) begin
            r_q <= r_q + 1'b1;
        end
    end

endmodule

// File: rtl/lif_spike_monitor.sv
// Summarises neuron spikes and membrane potential per window; outputs {count, peak u, min ISI}.
// Latency: summary is visible 1 cycle after the closing sample.
// Backpressure: out_* held while out_valid && !out_ready; a new close overwrites and sets sticky overrun.
module lif_spike_monitor
    import lif_mon_pkg::*;
#(
    parameter int U_W   = DEF_U_W,
    parameter int WIN_W = DEF_WIN_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ISI_W = DEF_ISI_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [U_W-1:0]   u_in,
    input  logic [WIN_W-1:0] window_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [U_W-1:0]   out_u_max,
    output logic [ISI_W-1:0] out_isi_min,
    output logic             overrun
);

    logic [WIN_W-1:0] r_win_len;
    logic [U_W-1:0]   r_u_max;
    logic [ISI_W-1:0] r_isi_min;
    logic             r_seen;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_out_count;
    logic [U_W-1:0]   r_out_u_max;
    logic [ISI_W-1:0] r_out_isi_min;
    logic             r_overrun;

    logic [WIN_W-1:0] w_idx;
    logic             w_idx_max;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_max;
    logic [ISI_W-1:0] w_since;
    logic             w_since_max;
    logic             w_idle;
    logic             w_close;
    logic             w_spike;
    logic [CNT_W-1:0] w_cnt_next;
    logic [U_W-1:0]   w_u_next;
    logic [ISI_W-1:0] w_isi_cand;
    logic [ISI_W-1:0] w_isi_next;

    assign w_idle  = (r_win_len == '0);
    assign w_spike = enable && spike_in;
    // A saturated index also closes, so the window can never stall past its end.
    assign w_close = enable && !w_idle && ((w_idx == r_win_len - 1'b1) || w_idx_max);

    sat_counter #(.W(WIN_W)) u_win_idx (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_close || w_idle),
        .inc    (enable),
        .q      (w_idx),
        .at_max (w_idx_max)
    );

    sat_counter #(.W(CNT_W)) u_spike_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_close || w_idle),
        .inc    (w_spike),
        .q      (w_cnt),
        .at_max (w_cnt_max)
    );

    sat_counter #(.W(ISI_W)) u_since_last (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_spike),
        .inc    (enable),
        .q      (w_since),
        .at_max (w_since_max)
    );

    // Accumulator values including this cycle's sample, as captured at a close.
    assign w_cnt_next = (w_spike && !w_cnt_max) ? w_cnt + 1'b1 : w_cnt;
    assign w_u_next   = (enable && (u_in > r_u_max)) ? u_in : r_u_max;
    assign w_isi_cand = w_since_max ? {ISI_W{1'b1}} : w_since + 1'b1;
    assign w_isi_next = (w_spike && r_seen && (w_isi_cand < r_isi_min)) ? w_isi_cand : r_isi_min;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_len     <= window_len;
            r_u_max       <= '0;
            r_isi_min     <= '1;
            r_seen        <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_count   <= '0;
            r_out_u_max   <= '0;
            r_out_isi_min <= '1;
            r_overrun     <= 1'b0;
        end else begin
            if (w_spike) begin
                r_seen <= 1'b1;
            end

            if (w_close || w_idle) begin
                r_u_max   <= '0;
                r_isi_min <= '1;
                r_win_len <= window_len;
            end else begin
                r_u_max   <= w_u_next;
                r_isi_min <= w_isi_next;
            end

            if (w_close) begin
                r_out_valid   <= 1'b1;
                r_out_count   <= w_cnt_next;
                r_out_u_max   <= w_u_next;
                r_out_isi_min <= w_isi_next;
                if (r_out_valid && !out_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_count   = r_out_count;
    assign out_u_max   = r_out_u_max;
    assign out_isi_min = r_out_isi_min;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Self-checking bench for lif_spike_monitor: directed scenarios plus randomized traffic
// compared against a window/spike-timestamp reference model.
module tb_lif_spike_monitor;
    import lif_mon_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       spike_in;
    logic [2:0] u_in;
    logic [7:0] window_len;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_count;
    logic [2:0] out_u_max;
    logic [7:0] out_isi_min;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;

    lif_spike_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .spike_in    (spike_in),
        .u_in        (u_in),
        .window_len  (window_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_count   (out_count),
        .out_u_max   (out_u_max),
        .out_isi_min (out_isi_min),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: window holds the u samples and, per spike, the gap back to the previous spike.
    int       m_wlen;
    int       m_idx;
    int       m_gtime = 0;
    int       m_last  = -1;
    int       q_gap[$];
    int       q_u[$];
    logic     m_valid;
    logic     m_ovr;
    summary_t m_sum;

    task automatic model_step();
        bit close;
        bit accepted;
        int c, u, isi;
        if (reset) begin
            m_wlen = window_len; m_idx = 0; m_last = -1;
            q_gap.delete(); q_u.delete();
            m_valid = 1'b0; m_ovr = 1'b0;
            m_sum.count = 8'd0; m_sum.u_max = 3'd0; m_sum.isi_min = 8'hFF;
            return;
        end
        accepted = m_valid && out_ready;
        close = 1'b0;
        if (enable) begin
            if (m_wlen != 0) begin
                q_u.push_back(int'(u_in));
                if (spike_in) q_gap.push_back(m_last < 0 ? -1 : m_gtime - m_last);
                if (m_idx == m_wlen - 1) close = 1'b1;
                m_idx++;
            end
            if (spike_in) m_last = m_gtime;
            m_gtime++;
        end
        if (close) begin
            c = (q_gap.size() > 255) ? 255 : q_gap.size();
            u = 0;
            foreach (q_u[k]) if (q_u[k] > u) u = q_u[k];
            isi = 255;
            foreach (q_gap[k]) if (q_gap[k] >= 0 && q_gap[k] < isi) isi = q_gap[k];
            if (m_valid && !out_ready) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_sum.count = c[7:0]; m_sum.u_max = u[2:0]; m_sum.isi_min = isi[7:0];
            q_gap.delete(); q_u.delete();
            m_idx = 0; m_wlen = window_len;
        end else begin
            if (accepted) m_valid = 1'b0;
            if (m_wlen == 0) begin
                m_wlen = window_len; m_idx = 0;
                q_gap.delete(); q_u.delete();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; spike_in = 1'b0; u_in = 3'd0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        window_len = 8'd4; out_ready = 1'b1;
        do_reset();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (out_count !== 8'd0) $display("FAIL reset_count got %0d want 0", out_count); else n_pass++;
        n_checks++; if (out_u_max !== 3'd0) $display("FAIL reset_umax got %0d want 0", out_u_max); else n_pass++;
        n_checks++; if (out_isi_min !== 8'hFF) $display("FAIL reset_isi got %0d want 255", out_isi_min); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %0b want 0", overrun); else n_pass++;
    endtask

    task automatic test_basic();
        bit       s[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int       u[4] = '{1, 5, 2, 3};
        window_len = 8'd4; out_ready = 1'b1;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            spike_in = s[i]; u_in = u[i][2:0];
            tick();
            if (i == 2) begin
                n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %0b want 0", out_valid); else n_pass++;
            end
        end
        enable = 1'b0; spike_in = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %0b want 1", out_valid); else n_pass++;
        n_checks++; if (out_count !== 8'd2) $display("FAIL basic_count got %0d want 2", out_count); else n_pass++;
        n_checks++; if (out_u_max !== 3'd5) $display("FAIL basic_umax got %0d want 5", out_u_max); else n_pass++;
        n_checks++; if (out_isi_min !== 8'd2) $display("FAIL basic_isi got %0d want 2", out_isi_min); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_accept_drop got %0b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_first_spike();
        window_len = 8'd8; out_ready = 1'b1;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            spike_in = (i == 3); u_in = 3'($urandom_range(0, 7));
            tick();
        end
        enable = 1'b0; spike_in = 1'b0;
        n_checks++; if (out_count !== 8'd1) $display("FAIL first_count got %0d want 1", out_count); else n_pass++;
        n_checks++; if (out_isi_min !== 8'hFF) $display("FAIL first_isi got %0d want 255", out_isi_min); else n_pass++;
        n_checks++; if (out_u_max !== m_sum.u_max) $display("FAIL first_umax got %0d want %0d", out_u_max, m_sum.u_max); else n_pass++;
    endtask

    task automatic test_cross_window();
        window_len = 8'd4; out_ready = 1'b1;
        do_reset();
        enable = 1'b1; u_in = 3'd2;
        for (int i = 0; i < 16; i++) begin
            spike_in = (i < 8) || (i == 14);
            tick();
            if (i == 7) begin
                n_checks++; if (out_count !== 8'd4) $display("FAIL cross_count got %0d want 4", out_count); else n_pass++;
                n_checks++; if (out_isi_min !== 8'd1) $display("FAIL cross_isi got %0d want 1", out_isi_min); else n_pass++;
            end
        end
        enable = 1'b0; spike_in = 1'b0;
        n_checks++; if (out_count !== 8'd1) $display("FAIL gap_count got %0d want 1", out_count); else n_pass++;
        n_checks++; if (out_isi_min !== 8'd7) $display("FAIL gap_isi got %0d want 7", out_isi_min); else n_pass++;
    endtask

    task automatic test_overrun();
        int u[6] = '{1, 0, 2, 1, 6, 4};
        window_len = 8'd2; out_ready = 1'b0;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            spike_in = (i >= 4); u_in = u[i][2:0];
            tick();
            if (i == 1) begin
                n_checks++; if ({out_valid, overrun} !== 2'b10) $display("FAIL ovr_first got %b want 10", {out_valid, overrun}); else n_pass++;
            end
            if (i == 3) begin
                n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set got %0b want 1", overrun); else n_pass++;
            end
        end
        enable = 1'b0; spike_in = 1'b0;
        n_checks++; if ({out_count, out_u_max, out_isi_min} !== {8'd2, 3'd6, 8'd1})
            $display("FAIL ovr_data got %0d/%0d/%0d want 2/6/1", out_count, out_u_max, out_isi_min); else n_pass++;
        n_checks++; if ({out_valid, overrun} !== 2'b11) $display("FAIL ovr_hold got %b want 11", {out_valid, overrun}); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++; if ({out_valid, overrun} !== 2'b01) $display("FAIL ovr_release got %b want 01", {out_valid, overrun}); else n_pass++;
    endtask

    task automatic test_idle();
        bit any_valid = 1'b0;
        window_len = 8'd0; out_ready = 1'b1;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            spike_in = 1'($urandom_range(0, 1)); u_in = 3'($urandom_range(0, 7));
            tick();
            if (out_valid) any_valid = 1'b1;
        end
        n_checks++; if (any_valid !== 1'b0) $display("FAIL idle_valid got 1 want 0"); else n_pass++;
        enable = 1'b0; window_len = 8'd3;
        tick();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            spike_in = 1'($urandom_range(0, 1)); u_in = 3'($urandom_range(0, 7));
            tick();
            if (i == 1) begin
                n_checks++; if (out_valid !== 1'b0) $display("FAIL idle_early got %0b want 0", out_valid); else n_pass++;
            end
        end
        enable = 1'b0;
        n_checks++; if ({out_valid, out_count, out_u_max, out_isi_min, overrun} !== {m_valid, m_sum, m_ovr})
            $display("FAIL idle_close got %0b/%0d/%0d/%0d want %0b/%0d/%0d/%0d", out_valid, out_count, out_u_max,
                     out_isi_min, m_valid, m_sum.count, m_sum.u_max, m_sum.isi_min); else n_pass++;
    endtask

    task automatic test_enable_toggle();
        window_len = 8'd4; out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            enable = (i % 2 == 0);
            spike_in = 1'($urandom_range(0, 1)); u_in = 3'($urandom_range(0, 7));
            tick();
            if (i == 5) begin
                n_checks++; if (out_valid !== 1'b0) $display("FAIL toggle_early got %0b want 0", out_valid); else n_pass++;
            end
            if (i == 6) begin
                n_checks++; if (out_valid !== 1'b1) $display("FAIL toggle_close got %0b want 1", out_valid); else n_pass++;
                n_checks++; if ({out_count, out_u_max, out_isi_min} !== m_sum)
                    $display("FAIL toggle_data got %0d/%0d/%0d want %0d/%0d/%0d", out_count, out_u_max, out_isi_min,
                             m_sum.count, m_sum.u_max, m_sum.isi_min); else n_pass++;
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_saturation();
        window_len = 8'd255; out_ready = 1'b1;
        do_reset();
        enable = 1'b1; spike_in = 1'b1;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 255; i++) begin
                u_in = (i == 100) ? 3'd7 : 3'($urandom_range(0, 6));
                tick();
            end
            n_checks++; if ({out_valid, out_count, out_u_max, out_isi_min} !== {1'b1, 8'd255, 3'd7, 8'd1})
                $display("FAIL sat_win%0d got %0b/%0d/%0d/%0d want 1/255/7/1", w, out_valid, out_count,
                         out_u_max, out_isi_min); else n_pass++;
        end
        enable = 1'b0; spike_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        window_len = 8'd4; out_ready = 1'b1;
        do_reset();
        tick();
        enable = 1'b1; spike_in = 1'b1; u_in = 3'd6;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; spike_in = 1'b0; u_in = 3'd1;
        n_checks++; if ({out_valid, out_count} !== 9'd0) $display("FAIL rstmid_out got %0b/%0d want 0/0", out_valid, out_count); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) begin
                n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_early got %0b want 0", out_valid); else n_pass++;
            end
        end
        enable = 1'b0;
        n_checks++; if ({out_valid, out_count, out_u_max, out_isi_min} !== {1'b1, 8'd0, 3'd1, 8'hFF})
            $display("FAIL rstmid_win got %0b/%0d/%0d/%0d want 1/0/1/255", out_valid, out_count, out_u_max,
                     out_isi_min); else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        window_len = 8'($urandom_range(1, 5)); out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 199) window_len = 8'($urandom_range(0, 6));
            enable    = ($urandom_range(0, 3) != 0);
            spike_in  = ($urandom_range(0, 9) < 4);
            u_in      = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
            n_checks++;
            if ({out_valid, out_count, out_u_max, out_isi_min, overrun} !== {m_valid, m_sum, m_ovr}) begin
                if (errs < 10)
                    $display("FAIL rand_cyc%0d got v%0b c%0d u%0d i%0d o%0b want v%0b c%0d u%0d i%0d o%0b", i,
                             out_valid, out_count, out_u_max, out_isi_min, overrun,
                             m_valid, m_sum.count, m_sum.u_max, m_sum.isi_min, m_ovr);
                errs++;
            end else begin
                n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; spike_in = 1'b0; u_in = 3'd0;
        window_len = 8'd4; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_first_spike();
        test_cross_window();
        test_overrun();
        test_idle();
        test_enable_toggle();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
